// File: rtl/pv2long_dmemresp_queue.sv
// pv2long_dmemresp_queue: aligning, sign/zero-extending FIFO for dmem load responses.
// Define PARC_DMEMRESP_QUEUE_BYPASS_EN to let an empty queue pass a response through in the same cycle.
module pv2long_dmemresp_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             enq_val,
   output logic             enq_rdy,
   input  logic [31:0]      enq_msg_data,
   input  logic [2:0]       enq_sel,
   input  logic [1:0]       enq_byte_off,
   output logic             deq_val,
   input  logic             deq_rdy,
   output logic [31:0]      deq_msg_data,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [31:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [31:0]      aligned;
   logic             empty, full, bypass_hit, enq_fire, deq_fire, wr, rd;
   assign byte_v = enq_msg_data[{enq_byte_off, 3'b000} +: 8];
   assign half_v = enq_msg_data[{enq_byte_off[1], 4'b0000} +: 16];
   always_comb begin
      aligned = enq_sel == 3'd0 ? enq_msg_data :
                enq_sel == 3'd1 ? {{24{byte_v[7]}}, byte_v} :
                enq_sel == 3'd2 ? {24'h0, byte_v} :
                enq_sel == 3'd3 ? {{16{half_v[15]}}, half_v} :
                enq_sel == 3'd4 ? {16'h0, half_v} : 32'h0;
   end
   assign empty = count_q == '0;
   assign full  = count_q == CNT_W'(DEPTH);
`ifdef PARC_DMEMRESP_QUEUE_BYPASS_EN
   assign bypass_hit = empty && enq_val && deq_rdy;
`else
   assign bypass_hit = 1'b0;
`endif
   assign enq_rdy      = reset && !flush && !full;
   assign deq_val      = reset && !flush && (!empty || bypass_hit);
   assign deq_msg_data = !reset ? 32'h0 : !empty ? mem_q[rptr_q] : bypass_hit ? aligned : 32'h0;
   assign count        = count_q;
   assign enq_fire = enq_val && enq_rdy;
   assign deq_fire = deq_val && deq_rdy;
   // a bypassed response is consumed directly and never occupies storage
   assign wr = enq_fire && !bypass_hit;
   assign rd = deq_fire && !empty;
   always_comb begin
      wptr_d  = wr ? wptr_q + PTR_W'(1) : wptr_q;
      rptr_d  = rd ? rptr_q + PTR_W'(1) : rptr_q;
      count_d = (wr && !rd) ? count_q + CNT_W'(1) :
                (rd && !wr) ? count_q - CNT_W'(1) : count_q;
   end
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= aligned;
   end
endmodule

// File: tb/tb_pv2long_dmemresp_queue.sv
// tb_pv2long_dmemresp_queue: directed vectors with a scoreboard queue checked by an independent deq monitor.
module tb_pv2long_dmemresp_queue;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        enq_val = 1'b0;
   logic        enq_rdy;
   logic [31:0] enq_msg_data = 32'h0;
   logic [2:0]  enq_sel = 3'd0;
   logic [1:0]  enq_byte_off = 2'd0;
   logic        deq_val;
   logic        deq_rdy = 1'b0;
   logic [31:0] deq_msg_data;
   logic [2:0]  count;
   logic [31:0] sb [$];
   int nvec = 0;
   int nerr = 0;

   pv2long_dmemresp_queue #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_msg_data(enq_msg_data),
      .enq_sel(enq_sel), .enq_byte_off(enq_byte_off),
      .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg_data(deq_msg_data),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (reset && deq_val && deq_rdy) begin
         if (sb.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL unexpected_deq: got %h expected no output", deq_msg_data);
         end else begin
            chk("deq_data", deq_msg_data, sb.pop_front());
         end
      end
   end

   // called at posedge+1; holds the request until accepted, returns at the next posedge+1
   task automatic push(input logic [31:0] d, input logic [2:0] s, input logic [1:0] o, input logic [31:0] e);
      bit done = 0;
      enq_val = 1'b1; enq_msg_data = d; enq_sel = s; enq_byte_off = o;
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if (enq_rdy) begin sb.push_back(e); done = 1; end
         @(posedge clk); #1;
      end
      enq_val = 1'b0;
      if (!done) begin nvec++; nerr++; $display("FAIL enq_timeout: got enq_rdy 0 expected 1 within 20 cycles"); end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin @(posedge clk); #1; end
      chk("drain_left", sb.size(), 0);
   endtask

   logic [31:0] av_d [14] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                              32'h8001F00F, 32'h8001F00F, 32'h8001F00F, 32'h8001F00F, 32'h8001F00F,
                              32'h8001F00F, 32'h8001F00F, 32'hDEADBEEF, 32'h8001F00F};
   logic [2:0]  av_s [14] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
   logic [1:0]  av_o [14] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd2};
   logic [31:0] av_e [14] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80, 32'h00000080,
                              32'hFFFF8001, 32'h0000F00F, 32'h0000F00F, 32'h00000000, 32'hFFFFF00F,
                              32'h00008001, 32'h00000000, 32'hDEADBEEF, 32'h00000000};

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", count, 0);
      chk("rst_enq_rdy", enq_rdy, 0);
      chk("rst_deq_val", deq_val, 0);
      chk("rst_deq_data", deq_msg_data, 0);
      reset = 1'b1;
      #1;
      chk("idle_enq_rdy", enq_rdy, 1);
      chk("idle_deq_val", deq_val, 0);
      deq_rdy = 1'b1;
      for (int i = 0; i < 14; i++) push(av_d[i], av_s[i], av_o[i], av_e[i]);
      drain();
      chk("align_count", count, 0);
      deq_rdy = 1'b0;
      for (int i = 1; i <= 4; i++) push(32'(i), 3'd0, 2'd0, 32'(i));
      chk("full_count", count, 4);
      chk("full_enq_rdy", enq_rdy, 0);
      enq_val = 1'b1; enq_msg_data = 32'd5; enq_sel = 3'd0; enq_byte_off = 2'd0;
      repeat (2) begin @(posedge clk); #1; chk("full_hold_count", count, 4); chk("full_hold_rdy", enq_rdy, 0); end
      deq_rdy = 1'b1;
      #1;
      chk("full_rdy_with_deq", enq_rdy, 0);
      push(32'd5, 3'd0, 2'd0, 32'd5);
      drain();
      chk("fill_drain_count", count, 0);
      deq_rdy = 1'b0;
      push(32'd10, 3'd0, 2'd0, 32'd10);
      push(32'd11, 3'd0, 2'd0, 32'd11);
      deq_rdy = 1'b1;
      for (int i = 12; i < 22; i++) begin
         push(32'(i), 3'd0, 2'd0, 32'(i));
         chk("steady_count", count, 2);
      end
      drain();
      chk("steady_drain_count", count, 0);
      enq_val = 1'b1; enq_msg_data = 32'hDEADBEEF; enq_sel = 3'd0; enq_byte_off = 2'd0;
      #1;
      sb.push_back(32'hDEADBEEF);
`ifdef PARC_DMEMRESP_QUEUE_BYPASS_EN
      chk("byp_deq_val", deq_val, 1);
      chk("byp_deq_data", deq_msg_data, 32'hDEADBEEF);
      @(posedge clk); #1;
      enq_val = 1'b0;
      chk("byp_count", count, 0);
`else
      chk("nobyp_deq_val", deq_val, 0);
      @(posedge clk); #1;
      enq_val = 1'b0;
      chk("nobyp_count", count, 1);
      chk("nobyp_deq_val_next", deq_val, 1);
`endif
      @(posedge clk); #1;
      chk("byp_after_count", count, 0);
      chk("byp_sb_empty", sb.size(), 0);
      deq_rdy = 1'b0;
      for (int i = 30; i < 33; i++) push(32'(i), 3'd0, 2'd0, 32'(i));
      chk("pre_flush_count", count, 3);
      flush = 1'b1; enq_val = 1'b1; enq_msg_data = 32'd99; deq_rdy = 1'b1;
      sb.delete();
      #1;
      chk("flush_enq_rdy", enq_rdy, 0);
      chk("flush_deq_val", deq_val, 0);
      @(posedge clk); #1;
      flush = 1'b0; enq_val = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_deq_val_after", deq_val, 0);
      repeat (3) @(posedge clk);
      #1;
      deq_rdy = 1'b0;
      push(32'd40, 3'd0, 2'd0, 32'd40);
      push(32'd41, 3'd0, 2'd0, 32'd41);
      chk("pre_reset_count", count, 2);
      reset = 1'b0;
      sb.delete();
      #1;
      chk("midrst_enq_rdy", enq_rdy, 0);
      chk("midrst_deq_val", deq_val, 0);
      chk("midrst_deq_data", deq_msg_data, 0);
      @(posedge clk); #1;
      chk("midrst_count", count, 0);
      reset = 1'b1;
      #1;
      chk("post_rst_count", count, 0);
      chk("post_rst_enq_rdy", enq_rdy, 1);
      chk("post_rst_deq_val", deq_val, 0);
      deq_rdy = 1'b1;
      push(32'h12345678, 3'd0, 2'd1, 32'h12345678);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
